// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 8-digit multiplexed hex display scanner.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIB_W      = 4;
  localparam int SEL_W      = 3;

  typedef logic [SEL_W-1:0] digit_sel_t;

  // Index of the most significant non-zero digit; 0 when every digit is 0.
  function automatic digit_sel_t top_digit(
    input logic [NUM_DIGITS*NIB_W-1:0] v
  );
    top_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[k*NIB_W +: NIB_W] != '0) top_digit = digit_sel_t'(k);
    end
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Dwell timer for the display scanner: counts 0..DIV-1 and flags the wrap
// cycle as a tick.
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit hex display scanner with frame-synchronous updates.
// Define SEG_SCAN_LZB_EN to blank leading zero digits.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*NIB_W-1:0] data_in,
  input  logic                        load,
  output logic [NIB_W-1:0]            nibble,
  output digit_sel_t                  sel,
  output logic                        blank,
  output logic                        pending,
  output logic                        frame_start
);

  logic                        tick;
  logic                        boundary;
  logic [NUM_DIGITS*NIB_W-1:0] disp_reg;
  logic [NUM_DIGITS*NIB_W-1:0] pend_reg;

  refresh_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign boundary = tick && (sel == digit_sel_t'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick) sel <= sel + 1'b1;
    end
  end

  // Display contents only move at a frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg <= '0;
      pend_reg <= '0;
      pending  <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        disp_reg <= data_in;
      end else if (pending) begin
        disp_reg <= pend_reg;
      end
      pending <= 1'b0;
    end else if (load) begin
      pend_reg <= data_in;
      pending  <= 1'b1;
    end
  end

  assign nibble = disp_reg[sel*NIB_W +: NIB_W];

`ifdef SEG_SCAN_LZB_EN
  assign blank = (sel > top_digit(disp_reg));
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a timeline-based
// reference model (DIV=4).
module tb_seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int FR  = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic [3:0]  nibble;
  logic [2:0]  sel;
  logic        blank;
  logic        pending;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  int          t = 0;
  logic [31:0] m_disp = '0;
  logic [31:0] m_pend = '0;
  logic        m_pf = 1'b0;

  seg_scan_ctrl #(
    .DIV (DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .load        (load),
    .nibble      (nibble),
    .sel         (sel),
    .blank       (blank),
    .pending     (pending),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic int exp_sel();
    return (t / DIV) % 8;
  endfunction

  function automatic logic exp_blank();
    int hi = 0;
`ifdef SEG_SCAN_LZB_EN
    for (int k = 0; k < 8; k++)
      if (((m_disp >> (4 * k)) & 32'hF) != 0) hi = k;
    return exp_sel() > hi;
`else
    hi = 0;
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cyc(input logic r, input logic ld, input logic [31:0] d);
    logic bnd;
    rst = r; load = ld; data_in = d;
    @(posedge clk);
    if (r) begin
      t = 0; m_disp = '0; m_pend = '0; m_pf = 1'b0;
    end else begin
      bnd = (t % FR) == FR - 1;
      if (bnd) begin
        if (ld) m_disp = d;
        else if (m_pf) m_disp = m_pend;
        m_pf = 1'b0;
      end else if (ld) begin
        m_pend = d; m_pf = 1'b1;
      end
      t++;
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    chk("sel", 32'(sel), 32'(exp_sel()));
    chk("nibble", 32'(nibble), (m_disp >> (4 * exp_sel())) & 32'hF);
    chk("pending", 32'(pending), 32'(m_pf));
    chk("frame_start", 32'(frame_start),
        32'((t > 0) && (t % FR == 0)));
    chk("blank", 32'(blank), 32'(exp_blank()));
  endtask

  task automatic idle_until(input int ph);
    while ((t % FR) != ph) cyc(1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] d;
    @(negedge clk);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    idle(40);

    idle_until(10);
    cyc(1'b0, 1'b1, 32'h89ABCDEF);
    idle(60);

    idle_until(5);
    cyc(1'b0, 1'b1, 32'h11111111);
    idle(5);
    cyc(1'b0, 1'b1, 32'h22222222);
    idle(70);

    idle_until(FR - 1);
    cyc(1'b0, 1'b1, 32'h00000A50);
    idle(40);

    cyc(1'b0, 1'b1, '0);
    idle(40);

    idle_until(3);
    cyc(1'b0, 1'b1, 32'h12345678);
    idle_until(5 * DIV + 1);
    cyc(1'b1, 1'b0, '0);
    idle(40);

    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      d = d & (32'hFFFFFFFF >> (4 * $urandom_range(0, 7)));
      if ($urandom_range(0, 7) == 0) d = '0;
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
